// File: rtl/mfcc_pkg.sv
// Shared types and fixed-point constants for the MFCC windowing stage.
// The coefficient helper runs at elaboration only and uses a series cosine so every tool folds it.
package mfcc_pkg;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} hw_state_t;

   localparam int COEF_FRAC_BITS = 16;
   localparam int ROUND_CONST    = 1 << (COEF_FRAC_BITS - 1);

   // round(scale * (0.54 - 0.46*cos(2*pi*n/(frame_size-1)))), scale = 2^coef_width - 1
   function automatic int hamming_coef(input int n, input int frame_size, input int coef_width);
      real pi, a, term, cs, scale;
      pi = 3.14159265358979323846;
      a  = 2.0 * pi * real'(n) / real'(frame_size - 1);
      if (a > pi) a = a - 2.0 * pi;
      term = 1.0;
      cs   = 1.0;
      for (int k = 1; k <= 30; k++) begin
         term = -term * a * a / real'((2 * k - 1) * (2 * k));
         cs   = cs + term;
      end
      scale = 1.0;
      for (int i = 0; i < coef_width; i++) scale = scale * 2.0;
      scale = scale - 1.0;
      return $rtoi(scale * (0.54 - 0.46 * cs) + 0.5);
   endfunction
endpackage

// File: rtl/hamming_window_apply_if.sv
// Buffer read port and windowed-sample stream of the Hamming stage.
interface hamming_window_apply_if #(parameter int WIDTH = 16);
   logic             buf_rd_en_o;
   logic             buf_valid_i;
   logic [WIDTH-1:0] buf_data_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] out_data_o;
   logic             out_last_o;

   modport master (output buf_rd_en_o, out_valid_o, out_data_o, out_last_o,
                   input  buf_valid_i, buf_data_i, out_ready_i);
   modport slave  (input  buf_rd_en_o, out_valid_o, out_data_o, out_last_o,
                   output buf_valid_i, buf_data_i, out_ready_i);
endinterface

// File: rtl/hamming_coef_rom.sv
// Synchronous-read Hamming coefficient ROM; addresses past the frame read as zero.
module hamming_coef_rom
   import mfcc_pkg::*;
#(
   parameter int COEF_WIDTH = 16,
   parameter int FRAME_SIZE = 306,
   parameter int AW         = 9
) (
   input  logic                  clk,
   input  logic [AW-1:0]         addr,
   output logic [COEF_WIDTH-1:0] coef
);
   logic [COEF_WIDTH-1:0] rom [FRAME_SIZE];

   for (genvar i = 0; i < FRAME_SIZE; i++) begin : g_rom
      localparam logic [COEF_WIDTH-1:0] C = COEF_WIDTH'(hamming_coef(i, FRAME_SIZE, COEF_WIDTH));
      assign rom[i] = C;
   end

   always_ff @(posedge clk)
      coef <= (int'(addr) < FRAME_SIZE) ? rom[addr] : '0;
endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; the head reads as zero while empty.
module sync_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [AW:0]   count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop_ok;

   assign pop_ok = pop && (count != '0);
   assign dout   = (count != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop_ok);
      end
   end
endmodule

// File: rtl/hamming_window_apply.sv
// Reads a frame from the MFCC buffer, applies the Hamming window with round/saturate,
// and streams the result to the FFT stage, then asks the buffer to slide.
module hamming_window_apply
   import mfcc_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int COEF_WIDTH = 16,
   parameter int FRAME_SIZE = 306,
   parameter int OUT_DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_start_i,
   hamming_window_apply_if.master  bus,
   output logic                    start_move_o,
   output logic                    busy_o,
   output logic                    overrun_o
);
   localparam int IW     = $clog2(FRAME_SIZE + 1);
   localparam int PW     = WIDTH + COEF_WIDTH + 1;
   localparam int CW     = $clog2(OUT_DEPTH) + 1;
   localparam int STAGES = 1;
   localparam int SMAX_I = 2 ** (WIDTH - 1) - 1;
   localparam logic [IW-1:0]        LAST_IDX = IW'(FRAME_SIZE - 1);
   localparam logic [IW-1:0]        END_IDX  = IW'(FRAME_SIZE);
   localparam logic signed [PW-1:0] RND      = PW'(ROUND_CONST);
   localparam logic signed [PW-1:0] SMAX     = PW'(SMAX_I);
   localparam logic signed [PW-1:0] SMIN     = PW'(-SMAX_I - 1);

   hw_state_t state, state_nxt;
   logic [IW-1:0]           rd_idx, out_idx;
   logic [STAGES:0]         vld_pipe, last_pipe;
   logic [CW-1:0]           fifo_count, inflight;
   logic [CW:0]             credit_use;
   logic [COEF_WIDTH-1:0]   coef, c_q;
   logic signed [WIDTH-1:0] x_q, res;
   logic signed [PW-1:0]    prod, rnd;
   logic                    rd_en, rd_acc, pop, push;

   hamming_coef_rom #(.COEF_WIDTH(COEF_WIDTH), .FRAME_SIZE(FRAME_SIZE), .AW(IW)) u_rom (
      .clk(clk), .addr(rd_idx), .coef(coef)
   );

   // vld_pipe[0]: read data on the bus this cycle; vld_pipe[STAGES]: product ready to push
   assign inflight   = CW'(vld_pipe[0]) + CW'(vld_pipe[STAGES]);
   assign credit_use = (CW+1)'(inflight) + (CW+1)'(fifo_count);
   assign rd_acc     = rd_en && bus.buf_valid_i;
   assign pop        = bus.out_valid_o && bus.out_ready_i;
   assign push       = vld_pipe[STAGES];
   assign busy_o     = (state != IDLE);

   always_comb begin
      state_nxt    = state;
      rd_en        = 1'b0;
      start_move_o = 1'b0;
      case (state)
         IDLE:  if (frame_start_i) state_nxt = READ;
         READ: begin
            rd_en = bus.buf_valid_i && (credit_use < (CW+1)'(OUT_DEPTH)) && (rd_idx < END_IDX);
            if (rd_en && rd_idx == LAST_IDX) state_nxt = DRAIN;
         end
         DRAIN: if (pop && out_idx == LAST_IDX) state_nxt = DONE;
         DONE: begin
            start_move_o = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   assign bus.buf_rd_en_o = rd_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rd_idx    <= '0;
         out_idx   <= '0;
         overrun_o <= 1'b0;
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         state     <= state_nxt;
         vld_pipe  <= {vld_pipe[STAGES-1:0], rd_acc};
         last_pipe <= {last_pipe[STAGES-1:0], rd_idx == LAST_IDX};
         if (state == IDLE && frame_start_i) begin
            rd_idx  <= '0;
            out_idx <= '0;
         end else begin
            if (rd_acc) rd_idx  <= rd_idx + IW'(1);
            if (pop)    out_idx <= out_idx + IW'(1);
         end
         if (state != IDLE && frame_start_i) overrun_o <= 1'b1;
      end
   end

   // ROM output and buffer data both arrive the cycle after the accepted read
   always_ff @(posedge clk)
      if (vld_pipe[0]) begin
         x_q <= signed'(bus.buf_data_i);
         c_q <= coef;
      end

   assign prod = PW'(x_q) * PW'({1'b0, c_q});
   assign rnd  = (prod + RND) >>> COEF_FRAC_BITS;

   always_comb begin
      res = WIDTH'(rnd);
      if (rnd > SMAX)      res = WIDTH'(SMAX);
      else if (rnd < SMIN) res = WIDTH'(SMIN);
   end

   sync_fifo #(.W(WIDTH + 1), .DEPTH(OUT_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n),
      .push(push), .din({last_pipe[STAGES], res}),
      .pop(pop), .dout({bus.out_last_o, bus.out_data_o}),
      .count(fifo_count)
   );
   assign bus.out_valid_o = (fifo_count != '0);
endmodule

// File: tb/tb_hamming_window_apply.sv
// Randomized scoreboard bench for hamming_window_apply with a buffer model and a reference window.
module tb_hamming_window_apply;
   localparam int N = 306;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_start = 1'b0;
   logic start_move, busy, overrun;

   hamming_window_apply_if #(.WIDTH(16)) bus ();

   hamming_window_apply #(.WIDTH(16), .COEF_WIDTH(16), .FRAME_SIZE(N), .OUT_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .bus(bus),
      .start_move_o(start_move), .busy_o(busy), .overrun_o(overrun)
   );

   always #5 clk = ~clk;

   typedef struct { int data; bit last; } exp_t;

   int   checks = 0, errors = 0;
   int   cyc = 0;
   int   coef [N];
   int   samp [N];
   int   frame_out [N];
   int   ref_out [N];
   int   ready_pct = 100;
   bit   stall_en = 1'b0;
   exp_t exp_q [$];
   int   n_out = 0;
   int   moves = 0, last_cyc = -10, move_cyc = 0, fs_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int model(input int x, input int n);
      real r;
      r = $floor(real'(x) * real'(coef[n]) / 65536.0 + 0.5);
      if (r > 32767.0)  r = 32767.0;
      if (r < -32768.0) r = -32768.0;
      return $rtoi(r);
   endfunction

   // downstream ready
   initial begin
      bus.out_ready_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.out_ready_i = ($urandom_range(99) < ready_pct);
      end
   end

   // frame buffer model: one-cycle read latency, optional valid gap
   initial begin
      int ptr, fs, outst;
      bit acc, pop;
      ptr = 0; fs = 0; outst = 0;
      bus.buf_valid_i = 1'b0;
      bus.buf_data_i  = '0;
      forever begin
         @(negedge clk);
         if (frame_start && !busy) begin
            ptr = 0; fs = cyc; outst = 0;
         end
         acc = bus.buf_rd_en_o && bus.buf_valid_i;
         pop = bus.out_valid_o && bus.out_ready_i;
         if (bus.buf_rd_en_o) check("read_credit", int'(outst < 4), 1);
         if (!bus.buf_valid_i) check("read_while_invalid", bus.buf_rd_en_o, 0);
         if (!rst_n) outst = 0;
         else        outst += int'(acc) - int'(pop);
         @(posedge clk); #1;
         if (acc && rst_n && ptr < N) begin
            bus.buf_data_i = 16'(samp[ptr]);
            ptr++;
         end
         bus.buf_valid_i = !(stall_en && (cyc - fs) >= 50 && (cyc - fs) <= 70);
      end
   end

   // output monitor / scoreboard
   initial begin
      bit hold;
      int held;
      exp_t e;
      hold = 1'b0; held = 0;
      forever begin
         @(negedge clk);
         if (frame_start && !busy) n_out = 0;
         if (start_move) begin
            moves++;
            move_cyc = cyc;
            check("move_after_last", cyc, last_cyc + 1);
         end
         if (hold && bus.out_valid_o) check("hold_stable", int'(bus.out_data_o), held);
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) check("unexpected_output", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("out_data", int'($signed(bus.out_data_o)), e.data);
               check("out_last", bus.out_last_o, e.last);
            end
            if (n_out < N) frame_out[n_out] = int'($signed(bus.out_data_o));
            if (bus.out_last_o) last_cyc = cyc;
            n_out++;
         end
         hold = rst_n && bus.out_valid_o && !bus.out_ready_i;
         held = int'(bus.out_data_o);
      end
   end

   task automatic start_frame();
      exp_t e;
      for (int n = 0; n < N; n++) begin
         e.data = model(samp[n], n);
         e.last = (n == N - 1);
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      frame_start = 1'b1;
      fs_cyc = cyc;
      @(posedge clk); #1;
      frame_start = 1'b0;
   endtask

   task automatic finish_frame(input string name, input int m0);
      int t;
      for (t = 0; t < 20000 && moves == m0; t++) @(negedge clk);
      check({name, "_move_pulse"}, moves, m0 + 1);
      @(negedge clk);
      check({name, "_busy_low"}, busy, 0);
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_out_count"}, n_out, N);
   endtask

   task automatic run_frame(input string name);
      int m0;
      m0 = moves;
      start_frame();
      finish_frame(name, m0);
   endtask

   task automatic wait_outputs(input string name, input int k);
      int t;
      for (t = 0; t < 20000 && n_out < k; t++) @(negedge clk);
      check({name, "_reached"}, int'(n_out >= k), 1);
   endtask

   task automatic randomize_samples();
      for (int n = 0; n < N; n++) samp[n] = int'($signed(16'($urandom)));
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_out_valid"}, bus.out_valid_o, 0);
      check({name, "_out_data"}, int'(bus.out_data_o), 0);
      check({name, "_out_last"}, bus.out_last_o, 0);
      check({name, "_rd_en"}, bus.buf_rd_en_o, 0);
      check({name, "_start_move"}, start_move, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_overrun"}, overrun, 0);
   endtask

   initial begin
      real pi;
      int  m0, diff;
      pi = 3.14159265358979323846;
      for (int n = 0; n < N; n++)
         coef[n] = $rtoi(65535.0 * (0.54 - 0.46 * $cos(2.0 * pi * real'(n) / real'(N - 1))) + 0.5);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // constant input: known first value and symmetric window
      for (int n = 0; n < N; n++) samp[n] = 16384;
      run_frame("basic");
      check("basic_first", frame_out[0], 1311);
      for (int n = 0; n < N / 2; n++) check("basic_symmetry", frame_out[n], frame_out[N - 1 - n]);
      check("basic_last_value", frame_out[N - 1], 1311);
      check("basic_frame_time", move_cyc - fs_cyc, N + 4);

      samp[0] = -32768;
      run_frame("neg_round");
      check("neg_first", frame_out[0], -2621);
      samp[0] = 32767;
      run_frame("pos_round");
      check("pos_first", frame_out[0], 2621);

      // random data at full rate, then the same data under backpressure
      randomize_samples();
      ready_pct = 100;
      run_frame("rand_full");
      check("rand_frame_time", move_cyc - fs_cyc, N + 4);
      ref_out = frame_out;
      ready_pct = 30;
      run_frame("backpressure");
      diff = 0;
      for (int n = 0; n < N; n++) if (frame_out[n] != ref_out[n]) diff++;
      check("bp_same_sequence", diff, 0);
      ready_pct = 100;

      // buffer valid gap
      randomize_samples();
      stall_en = 1'b1;
      run_frame("stall");
      check("stall_frame_time", move_cyc - fs_cyc, N + 4 + 21);
      stall_en = 1'b0;

      // frame_start while busy
      randomize_samples();
      ready_pct = 70;
      m0 = moves;
      start_frame();
      wait_outputs("overrun", 100);
      @(posedge clk); #1;
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      check("overrun_set", overrun, 1);
      check("overrun_busy", busy, 1);
      finish_frame("overrun", m0);
      check("overrun_sticky", overrun, 1);
      ready_pct = 100;

      // reset in the middle of a frame
      randomize_samples();
      m0 = moves;
      start_frame();
      wait_outputs("midreset", 150);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_idle_outputs("midreset");
      repeat (20) @(negedge clk);
      check("midreset_no_move", moves, m0);
      run_frame("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
